// File: rtl/dmem_unit.sv
// Byte-addressed data memory with fixed-latency load/store responses and range-fault detection.
// Optional alignment faulting is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_unit #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 1,
    parameter int ADDR_W    = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [63:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [63:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int EW = ADDR_W + 1;
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           accept;
    logic [3:0]     nbytes;
    logic [EW-1:0]  end_addr;
    logic           range_fault;
    logic           fault;
    logic [AW-1:0]  base_idx;
    logic [63:0]    load_data;
    logic           err_q;
    logic [63:0]    rdata_q;
    logic [7:0]     mem [MEM_BYTES];

    // Reset holds ready low; WAIT is the only state that blocks new requests.
    assign req_ready_o = rst_n_i && (state_q != WAIT);
    assign accept      = req_valid_i && req_ready_o;
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = rsp_valid_o && err_q;
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : 64'd0;

    always_comb begin
        nbytes = 4'd1;
        case (req_size_i)
            2'd0:    nbytes = 4'd1;
            2'd1:    nbytes = 4'd2;
            2'd2:    nbytes = 4'd4;
            default: nbytes = 4'd8;
        endcase
    end

    // One extra bit keeps addr + bytes from wrapping at the top of the address space.
    assign end_addr    = {1'b0, req_addr_i} + EW'(nbytes);
    assign range_fault = end_addr > EW'(MEM_BYTES);
    assign base_idx    = req_addr_i[AW-1:0];

`ifdef DMEM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |(req_addr_i[2:0] & (nbytes[2:0] - 3'd1));
    assign fault      = range_fault || misaligned;
`else
    assign fault      = range_fault;
`endif

    always_comb begin
        load_data = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                load_data[8*i +: 8] = mem[base_idx + AW'(i)];
            end
        end
    end

    // Memory contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk_i) begin
        if (accept && req_write_i && !fault) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < nbytes) begin
                    mem[base_idx + AW'(i)] <= req_wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q   <= 1'b0;
            rdata_q <= 64'd0;
        end else if (accept) begin
            err_q   <= fault;
            rdata_q <= (req_write_i || fault) ? 64'd0 : load_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning memory size in bytes (power of two, 64..65536).
REQ-002 SHALL have parameter LATENCY, default 1, meaning cycles from request acceptance to response (legal 1..8).
REQ-003 SHALL have parameter ADDR_W, default 64, meaning request address width.
REQ-004 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  input  1  request present.
REQ-007 req_ready_o  output  1  unit can accept a request this cycle.
REQ-008 req_write_i  input  1  1 = store, 0 = load.
REQ-009 req_size_i  input  2  access size: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-010 req_addr_i  input  ADDR_W  byte address of lowest byte.
REQ-011 req_wdata_i  input  64  store data; low bytes used.
REQ-012 rsp_valid_o  output  1  one-cycle response strobe.
REQ-013 rsp_rdata_o  output  64  load data, zero-extended; 0 for stores and errors.
REQ-014 rsp_err_o  output  1  access fault (valid only with rsp_valid_o).
REQ-015 busy_o  output  1  request in flight (state WAIT or RESP).

Function
REQ-016 SHALL implement states IDLE, WAIT, RESP.
REQ-017 Request accepted on a rising edge where req_valid_i & req_ready_o.
REQ-018 req_ready_o SHALL be 1 in IDLE and RESP, 0 in WAIT.
REQ-019 Acceptance: LATENCY=1 -> RESP; LATENCY>1 -> WAIT with counter loaded LATENCY-2.
REQ-020 WAIT: counter decrements each cycle; at 0 -> RESP.
REQ-021 RESP: rsp_valid_o=1 for exactly that cycle; acceptance in RESP follows REQ-019, else -> IDLE.
REQ-022 rsp_valid_o SHALL rise exactly LATENCY cycles after the acceptance edge; no response backpressure.
REQ-023 Fault when addr + bytes - 1 >= MEM_BYTES, computed without ADDR_W overflow (addr >= MEM_BYTES always faults).
REQ-024 Store commits little-endian at the acceptance edge; faulting stores SHALL write nothing.
REQ-025 Load data SHALL be sampled at the acceptance edge and held in a register until RESP.
REQ-026 Back-to-back store then load to same address SHALL return the stored bytes.
REQ-027 Unused upper bytes of rsp_rdata_o SHALL be 0; rsp_rdata_o=0 whenever rsp_valid_o=0.
REQ-028 Store accepted in RESP and store response SHALL not alter the concurrently presented response.

Reset
REQ-029 rst_n_i low SHALL immediately force IDLE, counter 0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, busy_o=0, req_ready_o=0 while asserted.
REQ-030 Reset mid-operation SHALL drop the pending response; a store already committed remains.
REQ-031 Memory array contents SHALL not be reset.
REQ-032 req_ready_o SHALL be 1 in the first cycle after rst_n_i deasserts.

Configuration
REQ-033 Macro DMEM_ALIGN_CHECK_EN defined: address not a multiple of access size SHALL fault (no write, rdata 0, rsp_err_o=1).
REQ-034 Macro undefined: misaligned accesses SHALL complete normally, bytes addressed sequentially.

Verification
REQ-035 LATENCY=3: store 8B 0x1122334455667788 @0x10, then load 8B @0x10 -> rsp_valid 3 cycles after each accept, rdata 0x1122334455667788, err 0.
REQ-036 Load 2B @0x12 after REQ-035 store -> rdata 0x0000000000005566; 1B @0x17 -> 0x11.
REQ-037 MEM_BYTES=1024: load 8B @0x3F9 -> err 1, rdata 0; @0x3F8 -> err 0; store @0xFFFFFFFFFFFFFFFC -> err 1, memory unchanged.
REQ-038 LATENCY=1, req_valid_i held high with 4 requests -> accepts every cycle, 4 consecutive rsp_valid pulses in order.
REQ-039 LATENCY=4: assert rst_n_i low 2 cycles after accepting a load -> no rsp_valid, busy_o=0, ready 1 after release.
REQ-040 DMEM_ALIGN_CHECK_EN defined: 4B load @0x102 -> err 1; undefined -> err 0, correct bytes.
